// File: rtl/lsu_pkg.sv
// Types, protocol constants and decode helpers for the LSU to L1.5 request path.
package lsu_pkg;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LH   = 4'd2,
      OP_LW   = 4'd3,
      OP_LBU  = 4'd4,
      OP_LHU  = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_RESP,
      ST_DONE
   } lsu_state_e;

   localparam logic [4:0] LOAD_RQ   = 5'b00000;
   localparam logic [4:0] STORE_RQ  = 5'b00001;
   localparam logic [2:0] SIZE_NONE = 3'b000;
   localparam logic [2:0] SIZE_B    = 3'b001;
   localparam logic [2:0] SIZE_H    = 3'b010;
   localparam logic [2:0] SIZE_W    = 3'b011;
   localparam logic [3:0] LOAD_RET  = 4'b0000;
   localparam logic [3:0] ST_ACK    = 4'b0100;

   // Opcodes above SW are reserved and behave like no operation.
   function automatic mem_op_e decode_op(input logic [3:0] raw);
      mem_op_e op;
      if (raw > 4'd8) op = OP_NONE;
      else            op = mem_op_e'(raw);
      return op;
   endfunction

   function automatic logic op_is_store(input mem_op_e op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic op_is_load(input mem_op_e op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic [2:0] op_size(input mem_op_e op);
      logic [2:0] sz;
      case (op)
         OP_LB, OP_LBU, OP_SB: sz = SIZE_B;
         OP_LH, OP_LHU, OP_SH: sz = SIZE_H;
         OP_LW, OP_SW:         sz = SIZE_W;
         default:              sz = SIZE_NONE;
      endcase
      return sz;
   endfunction

   function automatic logic op_misaligned(input mem_op_e op, input logic [1:0] lo);
      logic mis;
      case (op)
         OP_LH, OP_LHU, OP_SH: mis = lo[0];
         OP_LW, OP_SW:         mis = (lo != 2'b00);
         default:              mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic [31:0] align_addr(input mem_op_e op, input logic [31:0] a);
      logic [31:0] r;
      case (op)
         OP_LH, OP_LHU, OP_SH: r = {a[31:1], 1'b0};
         OP_LW, OP_SW:         r = {a[31:2], 2'b00};
         default:              r = a;
      endcase
      return r;
   endfunction

   // Big-endian byte order on the L1.5 side; narrow stores fill every lane.
   function automatic logic [31:0] store_format(input mem_op_e op, input logic [31:0] wdata);
      logic [31:0] r;
      case (op)
         OP_SB:   r = {4{wdata[7:0]}};
         OP_SH:   r = {2{wdata[7:0], wdata[15:8]}};
         OP_SW:   r = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
         default: r = 32'h0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_l15_req_if.sv
// Request/response bundle between the LSU (master) and the L1.5 arbiter (slave).
interface lsu_l15_req_if;
   logic [4:0]  mem_l15_rqtype;
   logic [2:0]  mem_l15_size;
   logic [31:0] mem_l15_address;
   logic [31:0] mem_l15_data;
   logic        mem_l15_val;
   logic        l15_mem_ack;
   logic        l15_mem_header_ack;
   logic        l15_mem_val;
   logic [63:0] l15_mem_data_0;
   logic [63:0] l15_mem_data_1;
   logic [3:0]  l15_mem_returntype;
   logic        mem_l15_req_ack;

   modport master (
      output mem_l15_rqtype, mem_l15_size, mem_l15_address, mem_l15_data, mem_l15_val,
      output mem_l15_req_ack,
      input  l15_mem_ack, l15_mem_header_ack,
      input  l15_mem_val, l15_mem_data_0, l15_mem_data_1, l15_mem_returntype
   );

   modport slave (
      input  mem_l15_rqtype, mem_l15_size, mem_l15_address, mem_l15_data, mem_l15_val,
      input  mem_l15_req_ack,
      output l15_mem_ack, l15_mem_header_ack,
      output l15_mem_val, l15_mem_data_0, l15_mem_data_1, l15_mem_returntype
   );
endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed lane of a 64-bit big-endian return line, swaps it to
// little-endian and sign/zero-extends it for the load opcode.
module lsu_load_align
   import lsu_pkg::*;
(
   input  mem_op_e     op,
   input  logic [2:0]  offset,
   input  logic [63:0] line,
   output logic [31:0] data
);

   logic [7:0] lane [8];
   logic [2:0] idx1;
   logic [2:0] idx2;
   logic [2:0] idx3;
   logic [7:0] b0;
   logic [7:0] b1;
   logic [7:0] b2;
   logic [7:0] b3;

   // lane[0] is the lowest-addressed byte, i.e. the most significant one.
   for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign lane[gi] = line[63 - 8*gi -: 8];
   end

   assign idx1 = offset + 3'd1;
   assign idx2 = offset + 3'd2;
   assign idx3 = offset + 3'd3;
   assign b0   = lane[offset];
   assign b1   = lane[idx1];
   assign b2   = lane[idx2];
   assign b3   = lane[idx3];

   always_comb begin
      data = 32'h0;
      case (op)
         OP_LB:   data = {{24{b0[7]}}, b0};
         OP_LBU:  data = {24'h0, b0};
         OP_LH:   data = {{16{b1[7]}}, b1, b0};
         OP_LHU:  data = {16'h0, b1, b0};
         OP_LW:   data = {b3, b2, b1, b0};
         default: data = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu_l15_req.sv
// LSU request engine: one outstanding load/store to the L1.5 at a time.
// Optional LSU_MISALIGN_CHECK_EN traps misaligned accesses instead of aligning them.
module lsu_l15_req
   import lsu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           mem_op,
   input  logic [31:0]          mem_addr,
   input  logic [31:0]          mem_wdata,
   lsu_l15_req_if.master        bus,
   output logic                 memOp_done,
   output logic [31:0]          load_data,
   output logic                 ld_addr_misaligned,
   output logic                 samo_addr_misaligned,
   output logic                 busy
);

   lsu_state_e  state_q, state_d;
   mem_op_e     op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        val_q, val_d;
   logic        done_q, done_d;
   logic [31:0] load_data_q, load_data_d;

   mem_op_e     new_op;
   logic        resp_match;
   logic [31:0] aligned_load;
   logic        unused_inputs;

`ifdef LSU_MISALIGN_CHECK_EN
   logic        ld_mis_q, ld_mis_d;
   logic        st_mis_q, st_mis_d;
`endif

   lsu_load_align u_align (
      .op     (op_q),
      .offset (addr_q[2:0]),
      .line   (bus.l15_mem_data_0),
      .data   (aligned_load)
   );

   // Header ack only steers the upstream arbiter; the second data beat is never needed.
   assign unused_inputs = ^{bus.l15_mem_data_1, bus.l15_mem_header_ack};

   always_comb begin
      new_op      = decode_op(mem_op);
      resp_match  = bus.l15_mem_val &&
                    (bus.l15_mem_returntype == (op_is_store(op_q) ? ST_ACK : LOAD_RET));
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      data_d      = data_q;
      val_d       = val_q;
      done_d      = 1'b0;
      load_data_d = load_data_q;
`ifdef LSU_MISALIGN_CHECK_EN
      ld_mis_d    = 1'b0;
      st_mis_d    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (new_op != OP_NONE) begin
               op_d   = new_op;
               data_d = store_format(new_op, mem_wdata);
`ifdef LSU_MISALIGN_CHECK_EN
               addr_d = mem_addr;
               if (op_misaligned(new_op, mem_addr[1:0])) begin
                  state_d     = ST_DONE;
                  done_d      = 1'b1;
                  load_data_d = 32'h0;
                  ld_mis_d    = op_is_load(new_op);
                  st_mis_d    = op_is_store(new_op);
               end else begin
                  state_d = ST_REQ;
                  val_d   = 1'b1;
               end
`else
               addr_d  = align_addr(new_op, mem_addr);
               state_d = ST_REQ;
               val_d   = 1'b1;
`endif
            end
         end
         ST_REQ: begin
            if (bus.l15_mem_ack) begin
               val_d = 1'b0;
               // A response can already be back in the cycle the request is taken.
               if (resp_match) begin
                  state_d     = ST_DONE;
                  done_d      = 1'b1;
                  load_data_d = op_is_load(op_q) ? aligned_load : 32'h0;
               end else begin
                  state_d = ST_WAIT_RESP;
               end
            end
         end
         ST_WAIT_RESP: begin
            if (resp_match) begin
               state_d     = ST_DONE;
               done_d      = 1'b1;
               load_data_d = op_is_load(op_q) ? aligned_load : 32'h0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_NONE;
         addr_q      <= 32'h0;
         data_q      <= 32'h0;
         val_q       <= 1'b0;
         done_q      <= 1'b0;
         load_data_q <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
         ld_mis_q    <= 1'b0;
         st_mis_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         val_q       <= val_d;
         done_q      <= done_d;
         load_data_q <= load_data_d;
`ifdef LSU_MISALIGN_CHECK_EN
         ld_mis_q    <= ld_mis_d;
         st_mis_q    <= st_mis_d;
`endif
      end
   end

   assign bus.mem_l15_val     = val_q;
   assign bus.mem_l15_rqtype  = op_is_store(op_q) ? STORE_RQ : LOAD_RQ;
   assign bus.mem_l15_size    = op_size(op_q);
   assign bus.mem_l15_address = addr_q;
   assign bus.mem_l15_data    = data_q;
   // Every response is consumed, including stale ones after an abandoned request.
   assign bus.mem_l15_req_ack = bus.l15_mem_val & ~rst;

   assign memOp_done = done_q;
   assign load_data  = load_data_q;
   assign busy       = (state_q != ST_IDLE);

`ifdef LSU_MISALIGN_CHECK_EN
   assign ld_addr_misaligned   = ld_mis_q;
   assign samo_addr_misaligned = st_mis_q;
`else
   assign ld_addr_misaligned   = 1'b0;
   assign samo_addr_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_l15_req.sv
// Randomized and directed bench for lsu_l15_req against a byte-level memory model.
module tb_lsu_l15_req;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  mem_op;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        memOp_done;
   logic [31:0] load_data;
   logic        ld_addr_misaligned;
   logic        samo_addr_misaligned;
   logic        busy;

   lsu_l15_req_if bus ();

   lsu_l15_req dut (
      .clk                  (clk),
      .rst                  (rst),
      .mem_op               (mem_op),
      .mem_addr             (mem_addr),
      .mem_wdata            (mem_wdata),
      .bus                  (bus),
      .memOp_done           (memOp_done),
      .load_data            (load_data),
      .ld_addr_misaligned   (ld_addr_misaligned),
      .samo_addr_misaligned (samo_addr_misaligned),
      .busy                 (busy)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_load = 32'h0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      bus.l15_mem_header_ack = 1'($urandom);
   endtask

   task automatic drive_resp(input logic [3:0] rt, input logic [63:0] d0);
      bus.l15_mem_val        = 1'b1;
      bus.l15_mem_returntype = rt;
      bus.l15_mem_data_0     = d0;
      bus.l15_mem_data_1     = ~d0;
   endtask

   task automatic clear_resp();
      bus.l15_mem_val        = 1'b0;
      bus.l15_mem_returntype = 4'($urandom);
   endtask

   // Reference model: access width in bytes, 0 for no operation.
   function automatic int nbytes(input logic [3:0] op);
      case (op)
         4'd1, 4'd4, 4'd6: return 1;
         4'd2, 4'd5, 4'd7: return 2;
         4'd3, 4'd8:       return 4;
         default:          return 0;
      endcase
   endfunction

   function automatic bit is_st(input logic [3:0] op);
      return (op >= 4'd6) && (op <= 4'd8);
   endfunction

   // Memory byte j of the 32-bit field is value byte (j mod width).
   function automatic logic [31:0] model_store(input logic [3:0] op, input logic [31:0] wdata);
      int n;
      logic [31:0] r;
      n = nbytes(op);
      r = 32'h0;
      for (int j = 0; j < 4; j++) r[31 - 8*j -: 8] = 8'(wdata >> (8 * (j % n)));
      return r;
   endfunction

   // Assemble little-endian value from memory bytes off..off+n-1 of the line.
   function automatic logic [31:0] model_load(input logic [3:0] op, input logic [2:0] off,
                                              input logic [63:0] d0);
      int n;
      logic [31:0] v;
      n = nbytes(op);
      v = 32'h0;
      for (int i = 0; i < n; i++)
         v = v | (32'(8'(d0 >> (56 - 8 * (int'(off) + i)))) << (8 * i));
      if (op == 4'd1 && v[7])  v = v | 32'hFFFF_FF00;
      if (op == 4'd2 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic do_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [63:0] d0, input int ack_dly, input int resp_dly,
                         input bit junk);
      int          n;
      bit          st;
      bit          mis;
      logic [31:0] ea;
      logic [3:0]  good_rt;
      logic [3:0]  bad_rt;
      n  = nbytes(op);
      st = is_st(op);
      mem_op    = op;
      mem_addr  = addr;
      mem_wdata = wdata;
      tick();
      mem_op    = 4'd0;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      if (n == 0) begin
         check_eq("nop_busy", 64'(busy), 64'(0));
         check_eq("nop_val", 64'(bus.mem_l15_val), 64'(0));
         return;
      end
      mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_CHECK_EN
      if (mis) begin
         check_eq("mis_val", 64'(bus.mem_l15_val), 64'(0));
         check_eq("mis_done", 64'(memOp_done), 64'(1));
         check_eq("mis_ldflag", 64'(ld_addr_misaligned), 64'(!st));
         check_eq("mis_stflag", 64'(samo_addr_misaligned), 64'(st));
         exp_load = 32'h0;
         tick();
         check_eq("mis_done_end", 64'(memOp_done), 64'(0));
         check_eq("mis_flags_end", 64'({ld_addr_misaligned, samo_addr_misaligned}), 64'(0));
         check_eq("mis_busy_end", 64'(busy), 64'(0));
         return;
      end
`else
      if (mis) check_eq("mis_noflag", 64'({ld_addr_misaligned, samo_addr_misaligned}), 64'(0));
`endif
      ea      = addr & ~32'(n - 1);
      good_rt = st ? ST_ACK : LOAD_RET;
      bad_rt  = st ? LOAD_RET : ST_ACK;
      for (int k = 0; k <= ack_dly; k++) begin
         check_eq("req_val", 64'(bus.mem_l15_val), 64'(1));
         check_eq("req_addr", 64'(bus.mem_l15_address), 64'(ea));
         check_eq("req_rqtype", 64'(bus.mem_l15_rqtype), st ? 64'(5'b00001) : 64'(5'b00000));
         check_eq("req_size", 64'(bus.mem_l15_size), (n == 1) ? 64'(1) : (n == 2) ? 64'(2) : 64'(3));
         if (st) check_eq("req_data", 64'(bus.mem_l15_data), 64'(model_store(op, wdata)));
         check_eq("req_busy", 64'(busy), 64'(1));
         if (k == ack_dly) break;
         mem_op = 4'($urandom_range(1, 8));
         tick();
      end
      bus.l15_mem_ack = 1'b1;
      if (resp_dly == 0) begin
         drive_resp(good_rt, d0);
         #1;
         check_eq("reqack_fast", 64'(bus.mem_l15_req_ack), 64'(1));
      end
      tick();
      bus.l15_mem_ack = 1'b0;
      clear_resp();
      if (resp_dly > 0) begin
         for (int k = 0; k < resp_dly; k++) begin
            check_eq("wait_val", 64'(bus.mem_l15_val), 64'(0));
            check_eq("wait_done", 64'(memOp_done), 64'(0));
            check_eq("wait_busy", 64'(busy), 64'(1));
            if (k < resp_dly - 1) tick();
         end
         if (junk) begin
            drive_resp(bad_rt, ~d0);
            #1;
            check_eq("junk_reqack", 64'(bus.mem_l15_req_ack), 64'(1));
            tick();
            clear_resp();
            check_eq("junk_done", 64'(memOp_done), 64'(0));
            check_eq("junk_busy", 64'(busy), 64'(1));
         end
         drive_resp(good_rt, d0);
         #1;
         check_eq("reqack", 64'(bus.mem_l15_req_ack), 64'(1));
         tick();
         clear_resp();
      end
      mem_op   = 4'd0;
      exp_load = st ? 32'h0 : model_load(op, ea[2:0], d0);
      check_eq("done", 64'(memOp_done), 64'(1));
      check_eq("load_data", 64'(load_data), 64'(exp_load));
      check_eq("done_flags", 64'({ld_addr_misaligned, samo_addr_misaligned}), 64'(0));
      check_eq("done_busy", 64'(busy), 64'(1));
      tick();
      check_eq("done_end", 64'(memOp_done), 64'(0));
      check_eq("idle_busy", 64'(busy), 64'(0));
      check_eq("load_hold", 64'(load_data), 64'(exp_load));
      $display("txn op=%0d addr=%08h wdata=%08h ack_dly=%0d resp_dly=%0d junk=%0d load=%08h",
               op, addr, wdata, ack_dly, resp_dly, junk, exp_load);
   endtask

   initial begin
      rst                    = 1'b1;
      mem_op                 = 4'd0;
      mem_addr               = 32'h0;
      mem_wdata              = 32'h0;
      bus.l15_mem_ack        = 1'b0;
      bus.l15_mem_header_ack = 1'b0;
      bus.l15_mem_val        = 1'b1;
      bus.l15_mem_returntype = LOAD_RET;
      bus.l15_mem_data_0     = 64'h0;
      bus.l15_mem_data_1     = 64'h0;
      tick();
      tick();
      check_eq("rst_val", 64'(bus.mem_l15_val), 64'(0));
      check_eq("rst_done", 64'(memOp_done), 64'(0));
      check_eq("rst_load", 64'(load_data), 64'(0));
      check_eq("rst_flags", 64'({ld_addr_misaligned, samo_addr_misaligned}), 64'(0));
      check_eq("rst_busy", 64'(busy), 64'(0));
      check_eq("rst_addr", 64'(bus.mem_l15_address), 64'(0));
      check_eq("rst_fields", 64'({bus.mem_l15_rqtype, bus.mem_l15_size}), 64'(0));
      check_eq("rst_reqack", 64'(bus.mem_l15_req_ack), 64'(0));
      rst = 1'b0;
      clear_resp();
      tick();

      do_txn(4'd3, 32'h0000_1000, 32'h0, 64'h1122_3344_5566_7788, 1, 2, 1'b0);
      check_eq("lw_1000", 64'(load_data), 64'(32'h4433_2211));
      do_txn(4'd1, 32'h0000_1007, 32'h0, 64'h0000_0000_0000_0080, 0, 0, 1'b0);
      check_eq("lb_1007", 64'(load_data), 64'(32'hFFFF_FF80));
      do_txn(4'd4, 32'h0000_1007, 32'h0, 64'h0000_0000_0000_0080, 0, 0, 1'b0);
      check_eq("lbu_1007", 64'(load_data), 64'(32'h0000_0080));

      // Reset while waiting for the response, then a stale response in IDLE.
      mem_op   = 4'd3;
      mem_addr = 32'h0000_4000;
      tick();
      mem_op = 4'd0;
      check_eq("abort_val", 64'(bus.mem_l15_val), 64'(1));
      bus.l15_mem_ack = 1'b1;
      tick();
      bus.l15_mem_ack = 1'b0;
      check_eq("abort_wait", 64'({busy, bus.mem_l15_val}), 64'(2'b10));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_load = 32'h0;
      check_eq("abort_busy", 64'(busy), 64'(0));
      check_eq("abort_outs", 64'({bus.mem_l15_val, memOp_done, ld_addr_misaligned,
                                  samo_addr_misaligned}), 64'(0));
      check_eq("abort_load", 64'(load_data), 64'(0));
      check_eq("abort_addr", 64'(bus.mem_l15_address), 64'(0));
      tick();
      drive_resp(LOAD_RET, 64'hDEAD_BEEF_CAFE_F00D);
      #1;
      check_eq("stale_reqack", 64'(bus.mem_l15_req_ack), 64'(1));
      tick();
      clear_resp();
      check_eq("stale_done", 64'(memOp_done), 64'(0));
      check_eq("stale_busy", 64'(busy), 64'(0));
      $display("txn reset-abort addr=00004000 stale response consumed");

      do_txn(4'd7, 32'h0000_2002, 32'h0000_ABCD, 64'h0, 0, 1, 1'b0);
      check_eq("sh_2002_load", 64'(load_data), 64'(0));
      do_txn(4'd3, 32'h0000_3001, 32'h0, 64'h8877_6655_4433_2211, 0, 1, 1'b0);
      do_txn(4'd8, 32'h0000_5004, 32'h1234_5678, 64'h0, 5, 2, 1'b1);

      for (int t = 0; t < 150; t++) begin
         do_txn(4'($urandom_range(0, 15)), $urandom, $urandom, {$urandom, $urandom},
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_l15_req.md
LSU_L15_REQ -- requirements
Module: lsu_l15_req

Interface
REQ-001 The block SHALL have ports clk (input, 1, clock) and rst (input, 1, synchronous active-high reset); one clock, reset is synchronous and active-high.
REQ-002 The block SHALL have input mem_op (4): 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; codes 9-15 are treated as none.
REQ-003 The block SHALL have input mem_addr (32), the effective address from execute.
REQ-004 The block SHALL have input mem_wdata (32), the store data in little-endian order.
REQ-005 The block SHALL have outputs mem_l15_rqtype (5), mem_l15_size (3), mem_l15_address (32), mem_l15_data (32) and mem_l15_val (1), forming the request to the L1.5 arbiter.
REQ-006 The block SHALL have inputs l15_mem_ack (1) and l15_mem_header_ack (1), the request accept signals.
REQ-007 The block SHALL have inputs l15_mem_val (1), l15_mem_data_0 (64), l15_mem_data_1 (64) and l15_mem_returntype (4), the response.
REQ-008 The block SHALL have output mem_l15_req_ack (1), the response consumed.
REQ-009 The block SHALL have outputs memOp_done (1 pulse), load_data (32), ld_addr_misaligned (1), samo_addr_misaligned (1) and busy (1).

Function
REQ-010 The FSM SHALL have states IDLE, REQ, WAIT_RESP and DONE.
REQ-011 In IDLE, a nonzero mem_op SHALL latch op, address and data, and the FSM SHALL enter REQ next cycle; mem_op is ignored in every other state.
REQ-012 In REQ, mem_l15_val SHALL be 1 with stable fields until the cycle in which l15_mem_ack=1; it SHALL then enter WAIT_RESP, or DONE if l15_mem_val with a matching returntype arrives in the same cycle.
REQ-013 In WAIT_RESP, it SHALL wait for l15_mem_val=1 with returntype LOAD_RET (loads) or ST_ACK (stores); mem_l15_req_ack SHALL be 1 in that cycle; non-matching responses SHALL be acked and ignored.
REQ-014 DONE SHALL last exactly one cycle with memOp_done=1 and load_data valid, then return to IDLE.
REQ-015 Minimum latency SHALL be 3 cycles from accept to memOp_done: accept, REQ with ack and response, DONE.
REQ-016 rqtype SHALL be LOAD_RQ=5'b00000 or STORE_RQ=5'b00001; size SHALL be 3'b001 (B), 3'b010 (H) or 3'b011 (W).
REQ-017 Store data SHALL be byte-swapped to big-endian and replicated across the 32-bit field: SB uses the byte 4 times, SH uses the half twice.
REQ-018 Load data SHALL be taken from l15_mem_data_0 at big-endian byte offset mem_addr[2:0], swapped to little-endian, then zero- or sign-extended to 32 bits per op; l15_mem_data_1 is unused.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 load_data SHALL hold its value until the next DONE, and SHALL be 0 for stores.
REQ-021 l15_mem_header_ack SHALL NOT alter state; it is used only for arbitration upstream.

Reset
REQ-022 rst SHALL force IDLE and set all outputs to 0, including mem_l15_val, memOp_done, load_data and both flags.
REQ-023 rst asserted mid-transaction SHALL abandon it without issuing mem_l15_req_ack; a later stale response SHALL be acked and ignored while in IDLE.

Configuration
REQ-024 With LSU_MISALIGN_CHECK_EN defined: a halfword at an odd address, or a word with addr[1:0]!=0, SHALL issue no request, go directly to DONE next cycle, and set ld_addr_misaligned (load) or samo_addr_misaligned (store) to 1 for that DONE cycle only.
REQ-025 With LSU_MISALIGN_CHECK_EN undefined: the flags SHALL be tied to 0, and low address bits SHALL be cleared to natural alignment before the request is issued.

Structure
REQ-026 Package lsu_pkg SHALL hold the mem_op enum, the rqtype, size and returntype constants, and the FSM state enum.
REQ-027 Sub-module lsu_load_align SHALL perform the combinational lane select, swap and extension of REQ-018.
REQ-028 Total RTL SHALL be 120-400 lines.

Verification
REQ-029 LW at 0x1000, with ack 1 cycle after val and response 2 cycles later with data_0=0x11223344_55667788 -> rqtype 0, size 3'b011, memOp_done pulses once, load_data=0x44332211.
REQ-030 LB at 0x1007 with byte 0x80 at that lane -> load_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-031 SH at 0x2002 with wdata 0x0000ABCD -> mem_l15_data=0xCDABCDAB, size 3'b010; ST_ACK -> memOp_done, load_data=0.
REQ-032 LW at 0x3001: with the macro -> no mem_l15_val, memOp_done plus ld_addr_misaligned one cycle after accept; without it -> request address 0x3000.
REQ-033 Hold l15_mem_ack low for 5 cycles -> mem_l15_val and its fields stay stable; assert rst in WAIT_RESP -> IDLE next cycle, all outputs 0, and a later response is acked without memOp_done.
